// File: rtl/argmax.sv
// Sequential arg-max: snapshots DIM signed scores on start and scans one per clock.
// Reports the lowest index among equal maxima, with a one-cycle done pulse.
module argmax #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 10,
  parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] vec [0:DIM-1],
  output logic        [IDXW-1:0]       idx,
  output logic                         done
);

  localparam logic [0:0]    IDLE = 1'b0;
  localparam logic [0:0]    SCAN = 1'b1;
  localparam logic [IDXW:0] LAST = (IDXW+1)'(DIM - 1);
  localparam logic [IDXW:0] ONE  = (IDXW+1)'(1);

  logic [0:0]                   state_q, state_d;
  logic [IDXW:0]                cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] best_q, best_d;
  logic [IDXW-1:0]              best_idx_q, best_idx_d;
  logic [IDXW-1:0]              idx_q, idx_d;
  logic                         done_q, done_d;
  logic                         load_snap;

  logic signed [DATA_WIDTH-1:0] vec_r [0:DIM-1];
  logic signed [DATA_WIDTH-1:0] cur;
  logic                         greater;

  assign cur     = vec_r[cnt_q[IDXW-1:0]];
  // Strictly greater keeps the earlier index on ties.
  assign greater = (cur > best_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    load_snap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_snap  = 1'b1;
          best_d     = vec[0];
          best_idx_d = '0;
          cnt_d      = ONE;
          if (DIM == 1) begin
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (greater) begin
          best_d     = cur;
          best_idx_d = cnt_q[IDXW-1:0];
        end
        if (cnt_q == LAST) begin
          idx_d   = greater ? cnt_q[IDXW-1:0] : best_idx_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
    end
  end

  // The snapshot needs no reset: it is always reloaded before being read.
  always_ff @(posedge clk) begin
    if (load_snap) begin
      for (int i = 0; i < DIM; i++) begin
        vec_r[i] <= vec[i];
      end
    end
  end

  assign idx  = idx_q;
  assign done = done_q;

endmodule

// File: tb/tb_argmax.sv
// Scoreboard bench for argmax: DIM=6 and DIM=1 instances, expected results queued
// at stimulus time and popped by per-instance monitors on each done pulse.
module tb_argmax;

  typedef logic signed [15:0] v6_t [0:5];
  typedef struct {
    int idx;
    int due;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start6, start1;
  logic signed [15:0] vec6 [0:5];
  logic signed [15:0] vec1 [0:0];
  logic [2:0]        idx6;
  logic [0:0]        idx1;
  logic              done6, done1;

  int   cyc;
  int   total;
  int   bad;
  int   model6;
  int   model1;
  exp_t q6[$];
  exp_t q1[$];

  argmax #(.DATA_WIDTH(16), .DIM(6)) dut6 (
    .clk(clk), .reset(rst_n), .start(start6), .vec(vec6), .idx(idx6), .done(done6)
  );

  argmax #(.DATA_WIDTH(16), .DIM(1)) dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .vec(vec1), .idx(idx1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done6) begin
        if (q6.size() == 0) begin
          chk("dim6_unexpected_done", 1, 0);
        end else begin
          e = q6.pop_front();
          chk("dim6_idx", int'(idx6), e.idx);
          chk("dim6_done_cycle", cyc, e.due);
          model6 = e.idx;
          $display("dim6 result idx=%0d expected=%0d cycle=%0d", idx6, e.idx, cyc);
        end
      end else begin
        chk("dim6_idx_hold", int'(idx6), model6);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done1) begin
        if (q1.size() == 0) begin
          chk("dim1_unexpected_done", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("dim1_idx", int'(idx1), e.idx);
          chk("dim1_done_cycle", cyc, e.due);
          model1 = e.idx;
          $display("dim1 result idx=%0d expected=%0d cycle=%0d", idx1, e.idx, cyc);
        end
      end else begin
        chk("dim1_idx_hold", int'(idx1), model1);
      end
    end
  end

  task automatic issue6(input v6_t v, input int exp_idx);
    exp_t e;
    @(negedge clk);
    vec6   = v;
    start6 = 1'b1;
    e.idx  = exp_idx;
    e.due  = cyc + 6;
    q6.push_back(e);
    @(posedge clk);
    #1 start6 = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic issue1(input logic signed [15:0] v);
    exp_t e;
    @(negedge clk);
    vec1[0] = v;
    start1  = 1'b1;
    e.idx   = 0;
    e.due   = cyc + 1;
    q1.push_back(e);
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  initial begin
    v6_t va, vb;
    total  = 0;
    bad    = 0;
    model6 = 0;
    model1 = 0;
    start6 = 1'b0;
    start1 = 1'b0;
    vec6   = '{0, 0, 0, 0, 0, 0};
    vec1[0] = 16'sd0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_idx6", int'(idx6), 0);
    chk("reset_done6", int'(done6), 0);
    chk("reset_idx1", int'(idx1), 0);
    chk("reset_done1", int'(done1), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Back-to-back: negatives with a tie, positive tie, clear maximum.
    issue6('{-3, -1, -7, -1, -2, -9}, 1);
    issue6('{0, 5, 2, 5, 1, 4}, 1);
    issue6('{1, 2, 3, 9, 8, 0}, 3);
    // Extremes.
    issue6('{-32768, -32768, -32768, -32768, -32768, 32767}, 5);
    issue6('{7, 7, 7, 7, 7, 7}, 0);
    issue6('{32767, -32768, 0, 0, 0, 0}, 0);
    repeat (3) @(posedge clk);

    // vec change and a second start mid-scan must not disturb the result.
    va = '{4, -2, 6, 6, 1, 0};
    vb = '{0, 0, 0, 0, 0, 50};
    begin
      exp_t e;
      @(negedge clk);
      vec6   = va;
      start6 = 1'b1;
      e.idx  = 2;
      e.due  = cyc + 6;
      q6.push_back(e);
      @(posedge clk);
      #1 start6 = 1'b0;
      vec6 = vb;
      @(posedge clk);
      @(negedge clk);
      start6 = 1'b1;
      @(posedge clk);
      #1 start6 = 1'b0;
      repeat (3) @(posedge clk);
    end
    repeat (8) @(posedge clk);

    // Mid-scan reset after a nonzero result.
    issue6('{1, 2, 3, 9, 8, 0}, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec6   = '{0, 5, 2, 5, 1, 4};
    start6 = 1'b1;
    @(posedge clk);
    #1 start6 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset_done", int'(done6), 0);
    chk("midscan_reset_idx", int'(idx6), 0);
    model6 = 0;
    model1 = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    issue6('{-5, -4, -3, -2, -1, -6}, 4);
    repeat (3) @(posedge clk);

    // Single-element instance, back-to-back.
    issue1(-16'sd5);
    issue1(16'sd32767);
    issue1(-16'sd32768);
    repeat (4) @(posedge clk);

    for (int i = 0; i < 50 && (q6.size() != 0 || q1.size() != 0); i++) begin
      @(posedge clk);
    end
    chk("drain6", q6.size(), 0);
    chk("drain1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
